// File: rtl/qp_mem_arbiter.sv
// Arbitrates the single-port query-patch SRAM between the Wishbone slave and the engine.
// The engine has priority, and Wishbone is forced through after MAX_WAIT starved cycles.
module qp_mem_arbiter #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int NUM_QUERYS = 408,
  parameter int MAX_WAIT   = 16,
  parameter int AW         = $clog2(NUM_QUERYS),
  parameter int PW         = PATCH_SIZE * DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wbs_req,
  input  logic          wbs_we,
  input  logic [AW:0]   wbs_addr,
  input  logic [31:0]   wbs_wdata,
  output logic          wbs_ack,
  output logic [31:0]   wbs_rdata,
  input  logic          eng_req,
  input  logic          eng_we,
  input  logic [AW-1:0] eng_addr,
  input  logic [PW-1:0] eng_wpatch,
  output logic          eng_gnt,
  output logic          eng_rvalid,
  output logic [PW-1:0] eng_rpatch,
  output logic          mem_csb0,
  output logic          mem_web0,
  output logic [AW-1:0] mem_addr0,
  output logic [PW-1:0] mem_wpatch0,
  input  logic [PW-1:0] mem_rpatch0
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, WB_RD, WB_ACK} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic [31:0]   hold;
  logic          half_q;
  logic          wbs_gnt_int;
  logic          wb_issue;
  logic          wb_mem;

  assign eng_rpatch = mem_rpatch0;

  // Gating with rst_n keeps the SRAM deselected for the whole time reset is held.
  always_comb begin
    wbs_gnt_int = !eng_req || (wait_cnt == WW'(MAX_WAIT));
    wb_issue    = rst_n && (state == IDLE) && wbs_req && wbs_gnt_int;
    wb_mem      = wb_issue && (!wbs_we || wbs_addr[0]);
    eng_gnt     = rst_n && eng_req && !wb_issue;

    state_nxt = state;
    case (state)
      IDLE:    if (wb_issue) state_nxt = wbs_we ? WB_ACK : WB_RD;
      WB_RD:   state_nxt = WB_ACK;
      WB_ACK:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    mem_csb0    = 1'b1;
    mem_web0    = 1'b1;
    mem_addr0   = '0;
    mem_wpatch0 = '0;
    if (wb_mem) begin
      mem_csb0    = 1'b0;
      mem_web0    = wbs_we ? 1'b0 : 1'b1;
      mem_addr0   = wbs_addr[AW:1];
      mem_wpatch0 = {wbs_wdata[PW-33:0], hold};
    end else if (eng_gnt) begin
      mem_csb0    = 1'b0;
      mem_web0    = !eng_we;
      mem_addr0   = eng_addr;
      mem_wpatch0 = eng_wpatch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      hold       <= '0;
      half_q     <= 1'b0;
      wbs_rdata  <= '0;
      wbs_ack    <= 1'b0;
      eng_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      wbs_ack    <= (state_nxt == WB_ACK);
      eng_rvalid <= eng_gnt && !eng_we;

      if (wb_issue) half_q <= wbs_addr[0];
      if (wb_issue && wbs_we && !wbs_addr[0]) hold <= wbs_wdata;

      if (state == WB_RD)
        wbs_rdata <= half_q ? {{(64-PW){1'b0}}, mem_rpatch0[PW-1:32]} : mem_rpatch0[31:0];

      if (!wbs_req || wb_issue)
        wait_cnt <= '0;
      else if ((state == IDLE) && (wait_cnt != WW'(MAX_WAIT)))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule
